// File: rtl/bcd_tube_feeder.sv
// rtl/bcd_tube_feeder.sv - binary-to-BCD converter that feeds the 9-digit nixie tube controller.
// Optional macro BCD_TUBE_RAW_EN adds the RAW register (direct hex write to the tube).
module bcd_tube_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        tube_we,
    output logic [2:0]  tube_addr,
    output logic [31:0] tube_din
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] WR_LO = 2'd2;
    localparam logic [1:0] WR_HI = 2'd3;

    logic [1:0]  state;
    logic [31:0] value;
    logic [31:0] bin;
    logic [39:0] bcd;
    logic [39:0] adj;
    logic [4:0]  cnt;
    logic        ovf;
    logic        drop;
    logic        busy;
    logic        value_wr;
    logic        raw_wr;
`ifdef BCD_TUBE_RAW_EN
    logic [31:0] raw;
`endif

    assign busy     = (state != IDLE);
    assign value_wr = we && (addr == 3'b000);
`ifdef BCD_TUBE_RAW_EN
    assign raw_wr   = we && (addr == 3'b010);
`else
    assign raw_wr   = 1'b0;
`endif

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            value <= 32'd0;
            bin   <= 32'd0;
            bcd   <= 40'd0;
            cnt   <= 5'd0;
            ovf   <= 1'b0;
            drop  <= 1'b0;
`ifdef BCD_TUBE_RAW_EN
            raw   <= 32'd0;
`endif
        end else begin
            if (we && (addr == 3'b001)) begin
                drop <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (value_wr) begin
                        value <= din;
                        ovf   <= 1'b0;
                        bin   <= din;
                        bcd   <= 40'd0;
                        cnt   <= 5'd0;
                        state <= CONV;
                    end
`ifdef BCD_TUBE_RAW_EN
                    // Raw words reuse the write-out path: the low 32 bits of bcd go to 3'b110.
                    else if (raw_wr) begin
                        raw   <= din;
                        ovf   <= 1'b0;
                        bcd   <= {8'h00, din};
                        state <= WR_LO;
                    end
`endif
                end
                CONV: begin
                    bcd <= {adj[38:0], bin[31]};
                    bin <= {bin[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= WR_LO;
                    end
                end
                WR_LO: begin
                    ovf   <= (bcd[39:36] != 4'd0);
                    state <= WR_HI;
                end
                WR_HI: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Placed after the STATUS clear so a simultaneous new drop wins.
            if (busy && (value_wr || raw_wr)) begin
                drop <= 1'b1;
            end
        end
    end

    always_comb begin
        tube_we   = 1'b0;
        tube_addr = 3'b000;
        tube_din  = 32'd0;
        if (state == WR_LO) begin
            tube_we   = 1'b1;
            tube_addr = 3'b110;
            tube_din  = bcd[31:0];
        end else if (state == WR_HI) begin
            tube_we   = 1'b1;
            tube_addr = 3'b111;
            tube_din  = {28'd0, bcd[35:32]};
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            3'b000:  dout = value;
            3'b001:  dout = {29'd0, drop, ovf, busy};
`ifdef BCD_TUBE_RAW_EN
            3'b010:  dout = raw;
`endif
            default: dout = 32'd0;
        endcase
    end
endmodule
